// File: rtl/aemb_div_seq_if.sv
// rtl/aemb_div_seq_if.sv - start/result bundle between decode/ALU and the divide sequencer
//
// Purpose: groups the divider request (gena, div_stb, div_uns, operands) and
// result (div_busy, div_done, div_res, div_dbz) signals.
// Ports (modports):
//   master - pipeline side: drives gena, div_stb, div_uns, x_opa, x_opb;
//            observes div_busy, div_done, div_res, div_dbz.
//   slave  - divider side: the mirror image of master.
interface aemb_div_seq_if #(
  parameter int DW = 32
);
  logic          gena;
  logic          div_stb;
  logic          div_uns;
  logic [DW-1:0] x_opa;
  logic [DW-1:0] x_opb;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_res;
  logic          div_dbz;

  modport master (
    output gena, div_stb, div_uns, x_opa, x_opb,
    input  div_busy, div_done, div_res, div_dbz
  );

  modport slave (
    input  gena, div_stb, div_uns, x_opa, x_opb,
    output div_busy, div_done, div_res, div_dbz
  );
endinterface

// File: rtl/aemb_div_seq.sv
// rtl/aemb_div_seq.sv - iterative restoring integer divider for IDIV/IDIVU
//
// Purpose: computes rD = rB / rA one quotient bit per cycle. Operand
// magnitudes are divided unsigned and the quotient is negated at the end
// when the operand signs differ (signed ops only). Quotient truncates
// toward zero; the remainder is discarded.
// Ports:
//   gclk - clock, rising edge
//   grst - asynchronous active-high reset
//   dif  - aemb_div_seq_if.slave: gena/div_stb/div_uns/x_opa(divisor)/
//          x_opb(dividend) in; div_busy/div_done/div_res/div_dbz out
// Optional feature macro: AEMB_DIV_DBZ_EN - when defined, a zero divisor
// skips the iteration and returns quotient 0 with div_dbz=1.
module aemb_div_seq #(
  parameter int DW = 32,
  parameter int CW = 5
) (
  input  logic           gclk,
  input  logic           grst,
  aemb_div_seq_if.slave  dif
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rem_q, rem_d;    // partial remainder
  logic [DW-1:0] q_q, q_d;        // dividend shifts out the top, quotient in the bottom
  logic [DW-1:0] dvs_q, dvs_d;    // divisor magnitude
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] res_q, res_d;
`ifdef AEMB_DIV_DBZ_EN
  logic          dz_q, dz_d;      // current op has a zero divisor
  logic          dbz_q, dbz_d;
`endif

  logic [DW:0]   shifted;
  logic [DW-1:0] trial;
  logic [DW-1:0] opa_mag, opb_mag;
  logic          start;

  assign start   = dif.div_stb && dif.gena;
  assign opa_mag = (!dif.div_uns && dif.x_opa[DW-1]) ? -dif.x_opa : dif.x_opa;
  assign opb_mag = (!dif.div_uns && dif.x_opb[DW-1]) ? -dif.x_opb : dif.x_opb;

  // Remainder is always below the divisor, so the shifted value fits DW+1
  // bits and a non-negative trial difference fits DW bits.
  assign shifted = {rem_q, q_q[DW-1]};
  assign trial   = shifted[DW-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
`ifdef AEMB_DIV_DBZ_EN
    dz_d    = dz_q;
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = opb_mag;
          dvs_d   = opa_mag;
          rem_d   = '0;
          neg_d   = !dif.div_uns && (dif.x_opa[DW-1] ^ dif.x_opb[DW-1]);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef AEMB_DIV_DBZ_EN
          dz_d = (dif.x_opa == '0);
          if (dif.x_opa == '0) begin
            q_d     = '0;
            state_d = FIX;
          end
`endif
        end
      end
      RUN: begin
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = trial;
          q_d   = {q_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted[DW-1:0];
          q_d   = {q_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) state_d = FIX;
      end
      FIX: begin
        res_d   = neg_q ? -q_q : q_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
`ifdef AEMB_DIV_DBZ_EN
        dbz_d   = dz_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
`ifdef AEMB_DIV_DBZ_EN
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
`ifdef AEMB_DIV_DBZ_EN
      dz_q    <= dz_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign dif.div_busy = busy_q;
  assign dif.div_done = done_q;
  assign dif.div_res  = res_q;
`ifdef AEMB_DIV_DBZ_EN
  assign dif.div_dbz  = dbz_q;
`else
  assign dif.div_dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_aemb_div_seq.sv
// tb/tb_aemb_div_seq.sv - self-checking bench for aemb_div_seq
module tb_aemb_div_seq;
  logic gclk;
  logic grst;
  int   checks;
  int   errors;

  aemb_div_seq_if #(.DW(32)) dif ();

  aemb_div_seq #(.DW(32), .CW(5)) dut (
    .gclk (gclk),
    .grst (grst),
    .dif  (dif.slave)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference quotient from plain integer arithmetic.
  function automatic logic [31:0] model_q(input logic [31:0] b, input logic [31:0] a,
                                          input logic uns);
    longint sb, sa, q;
    if (a == 32'd0) begin
`ifdef AEMB_DIV_DBZ_EN
      return 32'd0;
`else
      if (uns) return 32'hFFFF_FFFF;
      return b[31] ? 32'd1 : 32'hFFFF_FFFF;
`endif
    end
    if (uns) return b / a;
    sb = longint'($signed(b));
    sa = longint'($signed(a));
    q  = sb / sa;
    return q[31:0];
  endfunction

  function automatic logic model_dbz(input logic [31:0] a);
`ifdef AEMB_DIV_DBZ_EN
    return a == 32'd0;
`else
    return 1'b0 && (a == 32'd0);
`endif
  endfunction

  function automatic int model_lat(input logic [31:0] a);
`ifdef AEMB_DIV_DBZ_EN
    return (a == 32'd0) ? 1 : 33;
`else
    return (a == 32'd0) ? 33 : 33;
`endif
  endfunction

  // Called away from the clock edge; returns #1 after the start edge.
  task automatic start(input string tag, input logic [31:0] b, input logic [31:0] a,
                       input logic uns);
    dif.x_opb   = b;
    dif.x_opa   = a;
    dif.div_uns = uns;
    dif.gena    = 1'b1;
    dif.div_stb = 1'b1;
    @(posedge gclk);
    #1;
    dif.div_stb = 1'b0;
    check({tag, " busy_after_start"}, {31'd0, dif.div_busy}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_dbz,
                           input int exp_lat, input bit noise, input bit rand_gena);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge gclk);
      #1;
      n++;
      if (dif.div_done) begin
        got = 1'b1;
      end else begin
        check({tag, " busy_running"}, {31'd0, dif.div_busy}, 32'd1);
        if (noise && n == 10) begin
          dif.gena    = 1'b1;
          dif.div_stb = 1'b1;
          dif.x_opa   = $urandom;
          dif.x_opb   = $urandom;
          dif.div_uns = ~dif.div_uns;
        end else begin
          dif.div_stb = 1'b0;
        end
        if (rand_gena) dif.gena = 1'($urandom_range(0, 1));
      end
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_at_done"}, {31'd0, dif.div_busy}, 32'd0);
    check({tag, " res"}, dif.div_res, exp_res);
    check({tag, " dbz"}, {31'd0, dif.div_dbz}, {31'd0, exp_dbz});
  endtask

  task automatic do_op(input string tag, input logic [31:0] b, input logic [31:0] a,
                       input logic uns, input bit noise, input bit rand_gena);
    start(tag, b, a, uns);
    wait_done(tag, model_q(b, a, uns), model_dbz(a), model_lat(a), noise, rand_gena);
  endtask

  initial begin
    logic [31:0] rb, ra;
    logic        ru;
    checks      = 0;
    errors      = 0;
    grst        = 1'b1;
    dif.gena    = 1'b0;
    dif.div_stb = 1'b0;
    dif.div_uns = 1'b0;
    dif.x_opa   = '0;
    dif.x_opb   = '0;

    #2;
    check("rst busy", {31'd0, dif.div_busy}, 32'd0);
    check("rst done", {31'd0, dif.div_done}, 32'd0);
    check("rst res", dif.div_res, 32'd0);
    check("rst dbz", {31'd0, dif.div_dbz}, 32'd0);
    @(negedge gclk);
    grst     = 1'b0;
    dif.gena = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge gclk);
      check("idle busy", {31'd0, dif.div_busy}, 32'd0);
      check("idle done", {31'd0, dif.div_done}, 32'd0);
      check("idle res", dif.div_res, 32'd0);
    end

    do_op("u100_7", 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    check("u100_7 direct", dif.div_res, 32'd14);
    @(negedge gclk);
    do_op("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 1'b0);
    check("s-100_7 direct", dif.div_res, 32'hFFFF_FFF2);
    @(negedge gclk);
    do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check("s_ovf direct", dif.div_res, 32'h8000_0000);
    @(negedge gclk);

    // Mid-run start ignored, then a back-to-back start in the done cycle.
    do_op("b2b_first", 32'd12345, 32'd3, 1'b1, 1'b1, 1'b0);
    do_op("b2b_second", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0, 1'b0);
    check("b2b_second direct", dif.div_res, 32'h0FFF_FFFF);
    @(negedge gclk);

    do_op("dbz_u", 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge gclk);
    do_op("dbz_s_neg", 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge gclk);

    for (int i = 0; i < 24; i++) begin
      rb = $urandom;
      ra = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 7) ra = 32'd0;
      ru = 1'($urandom_range(0, 1));
      do_op("rand", rb, ra, ru, 1'b0, 1'b1);
      if (i % 2 == 0) @(negedge gclk);
    end

    // Reset 10 cycles into RUN: immediate idle outputs and no done pulse.
    @(negedge gclk);
    start("rst_mid", 32'd777, 32'd5, 1'b1);
    repeat (10) @(posedge gclk);
    #3;
    grst = 1'b1;
    #1;
    check("rst_mid busy", {31'd0, dif.div_busy}, 32'd0);
    check("rst_mid done", {31'd0, dif.div_done}, 32'd0);
    check("rst_mid res", dif.div_res, 32'd0);
    repeat (3) @(negedge gclk);
    grst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge gclk);
      check("rst_mid no_done", {31'd0, dif.div_done}, 32'd0);
    end
    do_op("after_rst", 32'd1000, 32'd10, 1'b1, 1'b0, 1'b0);
    check("after_rst direct", dif.div_res, 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
